mips_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS CPU. It owns the program counter and drives the instruction-memory read port with a wait-request handshake. Each cycle it presents `instruction_fetch` / `PC_plus_four_fetch` to the fetch/decode pipeline register, which sits directly downstream. It also applies decode-resolved branch/jump redirects after the delay slot, and halts on a jump to address 0.

---
 rtl/mips_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_mips_fetch_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// -----------------------------------------------------------------------------
// mips_fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS CPU. Owns the program counter,
// drives the instruction-memory read port (wait-request handshake) and feeds
// the fetch/decode pipeline register. Decode-resolved branch/jump redirects
// are applied after the delay slot completes; a jump to HALT_ADDRESS stops
// fetching until reset.
//
// Optional feature macro: FETCH_HOLD_BUFFER_EN
//   defined   : a completion that arrives while stalled is captured into a
//               hold buffer (HOLD state) so every instruction is read once.
//   undefined : a stalled completion is discarded and the same address is
//               re-read every cycle until the stall is released.
//
// Parameters
//   RESET_VECTOR        PC value after reset
//   HALT_ADDRESS        fetching from this PC ends execution
//
// Ports
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   stall_fetch         hazard unit hold request
//   PC_src_decode       one-cycle redirect pulse from decode
//   PC_target_decode    redirect target address
//   imem_address        instruction-memory address (current PC)
//   imem_read           instruction-memory read request
//   imem_waitrequest    1 = read not complete this cycle
//   imem_readdata       instruction-memory read data
//   instruction_fetch   fetched word, 0 (NOP) when not valid
//   PC_plus_four_fetch  PC + 4 (wraps modulo 2^32)
//   fetch_valid         instruction_fetch holds a real instruction
//   halted              execution finished
// -----------------------------------------------------------------------------
module mips_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_fetch,
  input  logic        PC_src_decode,
  input  logic [31:0] PC_target_decode,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instruction_fetch,
  output logic [31:0] PC_plus_four_fetch,
  output logic        fetch_valid,
  output logic        halted
);

`ifdef FETCH_HOLD_BUFFER_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALTED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, HALTED = 2'd2} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic [31:0] next_pc;
  logic [31:0] pending_target;
  logic        pending_valid;
  logic        read_active;
  logic        complete;
  logic        holding;
  logic        consume;
  logic        latch_redirect;

`ifdef FETCH_HOLD_BUFFER_EN
  logic [31:0] hold_buffer;
`endif

  // Reading is gated by reset_n directly so the request drops the instant
  // reset asserts and rises in the very first cycle after release.
  always_comb begin
    read_active  = reset_n && (state == FETCH);
    complete     = read_active && !imem_waitrequest;
`ifdef FETCH_HOLD_BUFFER_EN
    holding      = (state == HOLD);
`else
    holding      = 1'b0;
`endif
    // The word on the outputs is handed downstream on this edge.
    consume      = !stall_fetch && (complete || holding);
    // A redirect seen during a wait state belongs after the in-flight delay
    // slot, so it is parked until that fetch completes.
    latch_redirect = read_active && imem_waitrequest && !stall_fetch && PC_src_decode;
    pc_plus_four = pc + 32'd4;
    if (pending_valid) begin
      next_pc = pending_target;
    end else if (PC_src_decode) begin
      next_pc = PC_target_decode;
    end else begin
      next_pc = pc_plus_four;
    end
  end

  // Output port drive; a held word comes from the buffer since memory is idle.
  always_comb begin
    imem_address       = pc;
    imem_read          = read_active;
    PC_plus_four_fetch = pc_plus_four;
    halted             = (state == HALTED);
    fetch_valid        = complete || holding;
    instruction_fetch  = 32'h0;
`ifdef FETCH_HOLD_BUFFER_EN
    if (holding) begin
      instruction_fetch = hold_buffer;
    end else if (complete) begin
      instruction_fetch = imem_readdata;
    end
`else
    if (complete) begin
      instruction_fetch = imem_readdata;
    end
`endif
  end

  // PC, redirect bookkeeping and state. HALTED never consumes or latches, so
  // it is only left through reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FETCH;
      pc             <= RESET_VECTOR;
      pending_target <= 32'h0;
      pending_valid  <= 1'b0;
`ifdef FETCH_HOLD_BUFFER_EN
      hold_buffer    <= 32'h0;
`endif
    end else if (consume) begin
      pc            <= next_pc;
      pending_valid <= 1'b0;
      state         <= (next_pc == HALT_ADDRESS) ? HALTED : FETCH;
    end else if (latch_redirect) begin
      pending_target <= PC_target_decode;
      pending_valid  <= 1'b1;
    end
`ifdef FETCH_HOLD_BUFFER_EN
    else if (complete && stall_fetch) begin
      hold_buffer <= imem_readdata;
      state       <= HOLD;
    end
`endif
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_stage
//
// Self-checking bench for mips_fetch_stage. A behavioural instruction memory
// returns (address ^ WORD_KEY) while read is requested and a junk word
// otherwise. Each scenario task drives one cycle at a time, pushes the
// expected port values onto a scoreboard and pops/compares them on the
// falling edge. Honours FETCH_HOLD_BUFFER_EN for the stall scenario.
// -----------------------------------------------------------------------------
module tb_mips_fetch_stage;

  localparam logic [31:0] WORD_KEY = 32'h5A5AC3C3;
  localparam logic [31:0] A0   = 32'hBFC00000;
  localparam logic [31:0] A4   = 32'hBFC00004;
  localparam logic [31:0] A8   = 32'hBFC00008;
  localparam logic [31:0] AC   = 32'hBFC0000C;
  localparam logic [31:0] T100 = 32'hBFC00100;
  localparam logic [31:0] T104 = 32'hBFC00104;
  localparam logic [31:0] T200 = 32'hBFC00200;

  typedef struct packed {
    logic        w;
    logic        st;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] ea;
    logic        erd;
    logic        ev;
    logic        eh;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_fetch;
  logic        PC_src_decode;
  logic [31:0] PC_target_decode;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest;
  logic [31:0] imem_readdata;
  logic [31:0] instruction_fetch;
  logic [31:0] PC_plus_four_fetch;
  logic        fetch_valid;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [98:0] sb[$];
  logic [98:0] got;
  logic [98:0] want;

  mips_fetch_stage dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall_fetch        (stall_fetch),
    .PC_src_decode      (PC_src_decode),
    .PC_target_decode   (PC_target_decode),
    .imem_address       (imem_address),
    .imem_read          (imem_read),
    .imem_waitrequest   (imem_waitrequest),
    .imem_readdata      (imem_readdata),
    .instruction_fetch  (instruction_fetch),
    .PC_plus_four_fetch (PC_plus_four_fetch),
    .fetch_valid        (fetch_valid),
    .halted             (halted)
  );

  always #5 clk = ~clk;

  // Memory model: junk while idle so a held word can't come from the bus.
  assign imem_readdata = imem_read ? (imem_address ^ WORD_KEY) : 32'hDEADBEEF;

  function automatic row_t r(input logic w, input logic st, input logic src,
                             input logic [31:0] tgt, input logic [31:0] ea,
                             input logic erd, input logic ev, input logic eh);
    r = '{w, st, src, tgt, ea, erd, ev, eh};
  endfunction

  // Drive one cycle's inputs, queue its expected outputs, move to the sample point.
  task automatic step(input row_t x);
    imem_waitrequest = x.w;
    stall_fetch      = x.st;
    PC_src_decode    = x.src;
    PC_target_decode = x.tgt;
    sb.push_back({x.ea, x.erd, x.ev, (x.ev ? (x.ea ^ WORD_KEY) : 32'h0), x.ea + 32'd4, x.eh});
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the fetch restarts in the same cycle.
  task automatic do_reset();
    imem_waitrequest = 1'b0;
    stall_fetch      = 1'b0;
    PC_src_decode    = 1'b0;
    PC_target_decode = 32'h0;
    reset_n          = 1'b0;
    #2;
    reset_n          = 1'b1;
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    imem_waitrequest = 1'b0;
    stall_fetch      = 1'b0;
    PC_src_decode    = 1'b1;
    PC_target_decode = T200;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({A0, 1'b0, 1'b0, 32'h0, A4, 1'b0});
      @(negedge clk);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_zero_wait();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,0,0,A4,1,1,0), r(0,0,0,0,A8,1,1,0)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL zero_wait cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_wait_states();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(1,0,0,0,A4,1,0,0), r(1,0,0,0,A4,1,0,0),
             r(0,0,0,0,A4,1,1,0), r(0,0,0,0,A8,1,1,0)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL wait_states cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,1,T100,A4,1,1,0), r(0,0,0,0,T100,1,1,0),
             r(0,0,0,0,T104,1,1,0)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL redirect cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_pending_redirect();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(1,0,1,T100,A4,1,0,0), r(1,0,0,0,A4,1,0,0),
             r(0,0,0,0,A4,1,1,0), r(0,0,0,0,T100,1,1,0), r(0,0,0,0,T104,1,1,0)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL pending_redirect cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  // Three stalled cycles starting at the A8 completion; a redirect during the
  // stall must be ignored.
  task automatic test_stall();
    row_t rows[$];
    int   reads;
    int   want_reads;
`ifdef FETCH_HOLD_BUFFER_EN
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,0,0,A4,1,1,0), r(0,1,0,0,A8,1,1,0),
             r(0,1,1,T200,A8,0,1,0), r(0,1,0,0,A8,0,1,0), r(0,0,0,0,A8,0,1,0),
             r(0,0,0,0,AC,1,1,0)};
    want_reads = 1;
`else
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,0,0,A4,1,1,0), r(0,1,0,0,A8,1,1,0),
             r(0,1,1,T200,A8,1,1,0), r(0,1,0,0,A8,1,1,0), r(0,0,0,0,A8,1,1,0),
             r(0,0,0,0,AC,1,1,0)};
    want_reads = 3;
`endif
    reads = 0;
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      if (rows[i].st && imem_read && (imem_address == A8)) reads++;
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL stall cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
    checks++;
    if (reads !== want_reads) begin
      errors++;
      $display("[TB] FAIL stall_read_count got %0d want %0d", reads, want_reads);
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,1,32'h0,A4,1,1,0), r(0,0,0,0,32'h0,0,0,1),
             r(0,0,1,T100,32'h0,0,0,1), r(1,1,0,0,32'h0,0,0,1), r(0,0,0,0,32'h0,0,0,1)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL halt cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
    do_reset();
    step(r(0,0,0,0,A0,1,1,0));
    got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL halt_restart got %h want %h", got, want);
    end
    next_cycle();
  endtask

  // Jump to the top of memory: PC+4 wraps to 0, and the following PC of 0 halts.
  task automatic test_wrap();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(0,0,1,32'hFFFFFFFC,A4,1,1,0),
             r(0,0,0,0,32'hFFFFFFFC,1,1,0), r(0,0,0,0,32'h0,0,0,1)};
    do_reset();
    foreach (rows[i]) begin
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL wrap cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  // Reset while a redirect is parked: the redirect must not survive.
  task automatic test_reset_abort();
    row_t rows[$];
    rows = '{r(0,0,0,0,A0,1,1,0), r(1,0,1,T100,A4,1,0,0), r(0,0,0,0,A0,1,1,0),
             r(0,0,0,0,A4,1,1,0), r(0,0,0,0,A8,1,1,0)};
    do_reset();
    foreach (rows[i]) begin
      if (i == 2) do_reset();
      step(rows[i]);
      got  = {imem_address, imem_read, fetch_valid, instruction_fetch, PC_plus_four_fetch, halted};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL reset_abort cycle %0d got %h want %h", i, got, want);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    imem_waitrequest = 1'b0;
    stall_fetch      = 1'b0;
    PC_src_decode    = 1'b0;
    PC_target_decode = 32'h0;
    next_cycle();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_pending_redirect();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
